// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// trap cause codes and the reset-time instruction.
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StExec = 2'd3
    } fetch_state_e;

    // Trap cause codes reported on trap_cause
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR   = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fall-through address; wraps modulo 2^32
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for the fetch stage: priority redirect mux
// (jalr > jal > branch > sequential) plus misaligned-target detection.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        jal_i,
    input  logic        jalr_i,
    input  logic        branch_taken_i,
    input  logic [31:0] target_addr_i,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic        redirect;
    logic [31:0] redirect_target;

    // Pick the highest-priority redirect; only a redirect can be misaligned
    always_comb begin
        redirect        = 1'b0;
        redirect_target = target_addr_i;
        if (jalr_i) begin
            redirect        = 1'b1;
            redirect_target = {target_addr_i[31:1], 1'b0};
        end else if (jal_i || branch_taken_i) begin
            redirect        = 1'b1;
            redirect_target = target_addr_i;
        end

        next_pc_o  = redirect ? redirect_target : pc_inc(pc_i);
        misalign_o = redirect && redirect_target[1];
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the req/gnt/rvalid handshake
// with instruction memory and hands one instruction per commit cycle to
// decode. Misaligned redirects and fetch bus errors vector to TRAP_VEC.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jal,
    input  logic        jalr,
    input  logic        branch_taken,
    input  logic [31:0] target_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] instr,
    output logic [31:0] program_counter,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        trap_valid,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_epc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         imem_req_q, imem_req_d;
    logic         instr_valid_q, instr_valid_d;
    logic         trap_valid_q, trap_valid_d;
    logic [1:0]   trap_cause_q, trap_cause_d;
    logic [31:0]  trap_epc_q, trap_epc_d;

    logic [31:0]  sel_next_pc;
    logic         sel_misalign;

    next_pc_sel u_next_pc_sel (
        .pc_i           (pc_q),
        .jal_i          (jal),
        .jalr_i         (jalr),
        .branch_taken_i (branch_taken),
        .target_addr_i  (target_addr),
        .next_pc_o      (sel_next_pc),
        .misalign_o     (sel_misalign)
    );

    // Sequencer next state, PC update, instruction capture and trap reporting
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        trap_valid_d = 1'b0;
        trap_cause_d = trap_cause_q;
        trap_epc_d   = trap_epc_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (imem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Responses outside this state are dropped by construction
                if (imem_rvalid) begin
                    if (imem_err) begin
                        trap_valid_d = 1'b1;
                        trap_cause_d = CAUSE_BUSERR;
                        trap_epc_d   = pc_q;
                        pc_d         = TRAP_VEC;
                        state_d      = StReq;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                if (sel_misalign) begin
                    trap_valid_d = 1'b1;
                    trap_cause_d = CAUSE_MISALIGN;
                    trap_epc_d   = pc_q;
                    pc_d         = TRAP_VEC;
                end else begin
                    pc_d = sel_next_pc;
                end
                state_d = StReq;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered status outputs track the state being entered
        imem_req_d    = (state_d == StReq);
        instr_valid_d = (state_d == StExec);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            trap_valid_q  <= 1'b0;
            trap_cause_q  <= CAUSE_NONE;
            trap_epc_q    <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            trap_valid_q  <= trap_valid_d;
            trap_cause_q  <= trap_cause_d;
            trap_epc_q    <= trap_epc_d;
        end
    end

    assign imem_req        = imem_req_q;
    assign imem_addr       = pc_q;
    assign instr           = instr_q;
    assign program_counter = pc_q;
    assign pc_plus4        = pc_inc(pc_q);
    assign instr_valid     = instr_valid_q;
    assign trap_valid      = trap_valid_q;
    assign trap_cause      = trap_cause_q;
    assign trap_epc        = trap_epc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory/redirect driver pushes the
// expected fetch addresses, commits and traps; a monitor pops and compares.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TVEC   = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jal = 1'b0, jalr = 1'b0, branch_taken = 1'b0;
    logic [31:0] target_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, imem_err = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr, program_counter, pc_plus4, trap_epc;
    logic        instr_valid, trap_valid;
    logic [1:0]  trap_cause;

    fetch_stage #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
        .clk             (clk),
        .rst             (rst),
        .jal             (jal),
        .jalr            (jalr),
        .branch_taken    (branch_taken),
        .target_addr     (target_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .imem_err        (imem_err),
        .instr           (instr),
        .program_counter (program_counter),
        .pc_plus4        (pc_plus4),
        .instr_valid     (instr_valid),
        .trap_valid      (trap_valid),
        .trap_cause      (trap_cause),
        .trap_epc        (trap_epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_trap;
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] data;
    } evt_t;

    typedef struct {
        int          gap;
        int          lat;
        bit          err;
        logic [31:0] rdata;
        bit          jalr;
        bit          jal;
        bit          br;
        logic [31:0] tgt;
    } txn_t;

    evt_t        evt_q[$];
    logic [31:0] fetch_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          abort   = 0;
    logic [31:0] model_pc;
    logic [1:0]  held_cause = 2'b00;
    logic [31:0] held_epc   = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge. Redirect
    // lines carry junk except where the driver overrides them in EXEC.
    task automatic tick();
        @(posedge clk);
        #1;
        jalr         = 1'($urandom);
        jal          = 1'($urandom);
        branch_taken = 1'($urandom);
        target_addr  = $urandom;
    endtask

    // Reference next-PC rule: jalr > jal > branch > +4, bit1 set traps
    task automatic model_next(input logic [31:0] pc, input bit j_r, input bit j,
                              input bit b, input logic [31:0] tgt,
                              output logic [31:0] nxt, output bit trap);
        logic [31:0] t;
        bit          redir;
        redir = 1'b1;
        if (j_r)          t = tgt & ~32'd1;
        else if (j || b)  t = tgt;
        else begin
            redir = 1'b0;
            t     = pc + 32'd4;
        end
        trap = redir && ((t % 4) >= 2);
        nxt  = trap ? TVEC : t;
    endtask

    // One fetch transaction as seen from the memory side
    task automatic do_txn(input txn_t t);
        int          n;
        logic [31:0] fpc, nxt;
        bit          trap;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!imem_req) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: got imem_req=0, expected 1 within 20 cycles");
            abort = 1;
            return;
        end
        fpc = model_pc;
        // Grant stall; stray responses during REQ must be dropped
        for (int i = 0; i < t.gap; i++) begin
            imem_rvalid = 1'($urandom);
            imem_err    = 1'($urandom);
            imem_rdata  = $urandom;
            tick();
        end
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_gnt    = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < t.lat; i++) tick();
        imem_rvalid = 1'b1;
        imem_err    = t.err;
        imem_rdata  = t.rdata;
        if (t.err) begin
            evt_q.push_back('{is_trap: 1'b1, cause: 2'b10, pc: fpc, data: 32'h0});
            model_pc = TVEC;
            fetch_q.push_back(model_pc);
            tick();
            imem_rvalid = 1'b0;
            imem_err    = 1'b0;
            return;
        end
        evt_q.push_back('{is_trap: 1'b0, cause: 2'b00, pc: fpc, data: t.rdata});
        tick();
        imem_rvalid  = 1'b0;
        // Now in the commit cycle: drive the real redirect inputs
        jalr         = t.jalr;
        jal          = t.jal;
        branch_taken = t.br;
        target_addr  = t.tgt;
        model_next(fpc, t.jalr, t.jal, t.br, t.tgt, nxt, trap);
        if (trap) evt_q.push_back('{is_trap: 1'b1, cause: 2'b01, pc: fpc, data: 32'h0});
        model_pc = nxt;
        fetch_q.push_back(model_pc);
        tick();
    endtask

    // Monitor: compare every visible fetch, commit and trap with the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (imem_req) begin
                if (fetch_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL fetch_unexpected: got request at %h, expected none", imem_addr);
                end else begin
                    check("imem_addr", imem_addr, fetch_q[0]);
                    if (imem_gnt) void'(fetch_q.pop_front());
                end
            end
            if (instr_valid || trap_valid) begin
                if (evt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL event_unexpected: got valid=%b trap=%b, expected none",
                             instr_valid, trap_valid);
                end else begin
                    evt_t e;
                    e = evt_q.pop_front();
                    check("event_kind", {31'd0, trap_valid}, {31'd0, e.is_trap});
                    if (e.is_trap) begin
                        check("trap_cause", {30'd0, trap_cause}, {30'd0, e.cause});
                        check("trap_epc", trap_epc, e.pc);
                        held_cause = e.cause;
                        held_epc   = e.pc;
                    end else begin
                        check("instr", instr, e.data);
                        check("program_counter", program_counter, e.pc);
                        check("pc_plus4", pc_plus4, e.pc + 32'd4);
                        check("held_cause", {30'd0, trap_cause}, {30'd0, held_cause});
                        check("held_epc", trap_epc, held_epc);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t dir_tbl[8];
        txn_t t;
        dir_tbl[0] = '{0, 0, 1'b0, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 32'h0};
        dir_tbl[1] = '{5, 0, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h0000_0041};
        dir_tbl[2] = '{0, 1, 1'b0, 32'h0000_0113, 1'b0, 1'b1, 1'b0, 32'h0000_0008};
        dir_tbl[3] = '{0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0};
        dir_tbl[4] = '{1, 2, 1'b0, 32'h0000_0213, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
        dir_tbl[5] = '{0, 0, 1'b0, 32'h0000_0313, 1'b0, 1'b0, 1'b1, 32'h0000_0022};
        dir_tbl[6] = '{0, 0, 1'b0, 32'h0000_0413, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC};
        dir_tbl[7] = '{0, 0, 1'b0, 32'h0000_0513, 1'b0, 1'b0, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_trap_valid", {31'd0, trap_valid}, 32'd0);
        check("rst_trap_cause", {30'd0, trap_cause}, 32'd0);
        check("rst_trap_epc", trap_epc, 32'd0);
        check("rst_pc", program_counter, RST_PC);

        // Reset during WAIT, then a stale response while in IDLE
        fetch_q.push_back(RST_PC);
        @(posedge clk);
        #1 rst = 1'b1;
        while (!imem_req) tick();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst      = 1'b0;
        tick();
        rst         = 1'b1;
        fetch_q.push_back(RST_PC);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        check("stale_instr", instr, NOP);
        check("stale_trap_valid", {31'd0, trap_valid}, 32'd0);
        check("stale_instr_valid", {31'd0, instr_valid}, 32'd0);
        model_pc = RST_PC;

        // Directed cases, then randomized traffic
        for (int i = 0; i < 8 && !abort; i++) do_txn(dir_tbl[i]);
        for (int i = 0; i < 200 && !abort; i++) begin
            t.gap   = $urandom_range(0, 3);
            t.lat   = $urandom_range(0, 2);
            t.err   = ($urandom_range(0, 7) == 0);
            t.rdata = $urandom;
            t.jalr  = ($urandom_range(0, 3) == 0);
            t.jal   = ($urandom_range(0, 3) == 0);
            t.br    = ($urandom_range(0, 2) == 0);
            t.tgt   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) t.tgt = t.tgt | 32'd2;
            if (t.jalr && $urandom_range(0, 1) == 1) t.tgt = t.tgt | 32'd1;
            do_txn(t);
        end

        repeat (4) tick();
        check("events_drained", evt_q.size(), 32'd0);
        check("fetch_pending", fetch_q.size(), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
